branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage block that resolves each branch against the prediction carried down the pipe from the fetch-stage predictor.
- Produces the registered predictor-update bundle and the mispredict redirect to fetch.
- Produces the RAS-repair hints: call/return-after-return and call.
- Suppresses wrong-path branches for a fixed window after a redirect; keeps resolve/miss debug counters.

Parameters:
- SQUASH_CYCLES, 2, cycles of wrong-path suppression after a mispredict (1..15)
- BIMODAL_W, 12, width of the prediction carry field returned to the predictor

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  pipeline stall; freezes capture and squash countdown
- ex_valid  in  1  instruction in execute is valid
- ex_is_branch  in  1  instruction is any control transfer
- ex_is_call  in  1  call (direct or indirect)
- ex_is_return  in  1  return
- ex_taken  in  1  actual direction (unconditional = 1)
- ex_target  in  32  actual target
- ex_pc4  in  32  instruction PC+4
- ex_pred_dir  in  1  predicted direction carried from fetch
- ex_pred_target  in  32  predicted next PC carried from fetch
- ex_carry  in  BIMODAL_W  prediction carry field from fetch
- dbg_sel  in  1  0 = resolved count, 1 = miss count
- bpred_update  out  1  update strobe to predictor
- bpred_pc4  out  32  PC+4 of resolved branch
- bpred_target  out  32  actual target
- bpred_dir  out  1  actual direction
- bpred_miss  out  1  resolved branch mispredicted
- bpred_carry  out  BIMODAL_W  carry field echoed back
- miss_pred  out  1  redirect strobe to fetch
- redirect_pc  out  32  correct next PC
- c_r_after_r  out  1  resolved call/return follows a resolved return
- is_call  out  1  resolved branch is a call
- squash_active  out  1  suppression window active
- dbg_count  out  32  selected debug counter

Behaviour:
- Reset: all outputs 0; state IDLE; squash counter 0; last_was_return 0; both counters 0. Reset overrides all other inputs, including mid-squash.
- Capture condition (cap): ex_valid & ex_is_branch & ~stall & state==IDLE.
- Miss: (ex_pred_dir != ex_taken) | (ex_taken & (ex_pred_target != ex_target)).
- Latency: all outputs registered; visible the cycle after capture.
- On cap, next cycle:
  - bpred_update=1; bpred_pc4/target/dir/carry take the captured values; bpred_miss=miss.
  - is_call=ex_is_call; c_r_after_r=(ex_is_call|ex_is_return)&last_was_return.
- On cap with miss, next cycle: miss_pred=1; redirect_pc = ex_taken ? ex_target : ex_pc4.
- Strobes: bpred_update and miss_pred are single-cycle pulses; low on any cycle without a capture in the previous cycle. Data outputs hold their last values.
- last_was_return: loads ex_is_return on every cap.
- FSM:
  - IDLE -> SQUASH on cap with miss; squash counter loads SQUASH_CYCLES.
  - In SQUASH, the counter decrements on each non-stall cycle; ex_valid branches are ignored (no update, no redirect, last_was_return unchanged).
  - SQUASH -> IDLE on the cycle the counter reaches 0.
  - squash_active = (state==SQUASH).
- Stall: no capture; squash counter holds; strobes low; counters hold.
- Counters: 32-bit, wrap at 2^32. resolved += 1 per cap; miss += 1 per cap with miss. dbg_count is combinational from dbg_sel.
- Non-branch valid instructions: no effect.
- Back-to-back correct branches: one update per cycle, no bubbles.

Decomposition:
- Shared package bpred_pkg: BIMODAL_W, squash state enum {IDLE, SQUASH}, miss-compare function.
- Sub-module: none; the FSM and counter live in this block.

Test Plan:
- Reset, then conditional branch: pred_dir=1, taken=1, targets equal 0x100, pc4=0x44 -> next cycle bpred_update=1, bpred_miss=0, miss_pred=0, bpred_target=0x100.
- Mispredict: pred_dir=1, taken=0, pc4=0x80, followed by 3 back-to-back valid branches, SQUASH_CYCLES=2 ->
  - miss_pred=1, redirect_pc=0x80;
  - squash_active high 2 cycles; the next 2 branches produce no update;
  - the third produces an update.
- Same direction, wrong target: pred_target=0x200, ex_target=0x300 -> bpred_miss=1, redirect_pc=0x300.
- Return then call (both correct): second capture -> c_r_after_r=1, is_call=1. Call then call -> c_r_after_r=0.
- Stall held 3 cycles during SQUASH -> squash_active stays high 3 extra cycles; no strobes. Reset asserted mid-squash -> state IDLE and all outputs 0 the next cycle.
- 5 branches, 2 mispredicted (squash windows free of branches):
  - dbg_sel=0 -> dbg_count=5;
  - dbg_sel=1 -> dbg_count=2.

Source files
------------

// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared branch-resolve types, widths and miss compare
package bpred_pkg;

  localparam int BIMODAL_W = 12;

  typedef enum logic {
    IDLE,
    SQUASH
  } squash_state_t;

  // Unconditional and taken branches also compare targets; not-taken ones only compare direction.
  function automatic logic branch_miss(
    input logic        pred_dir,
    input logic        taken,
    input logic [31:0] pred_target,
    input logic [31:0] target
  );
    return (pred_dir != taken) || (taken && (pred_target != target));
  endfunction

endpackage

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolution, redirect, RAS hints, squash window
module branch_resolve_unit #(
  parameter int SQUASH_CYCLES = 2,
  parameter int BIMODAL_W     = bpred_pkg::BIMODAL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_call,
  input  logic                 ex_is_return,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic [31:0]          ex_pc4,
  input  logic                 ex_pred_dir,
  input  logic [31:0]          ex_pred_target,
  input  logic [BIMODAL_W-1:0] ex_carry,
  input  logic                 dbg_sel,
  output logic                 bpred_update,
  output logic [31:0]          bpred_pc4,
  output logic [31:0]          bpred_target,
  output logic                 bpred_dir,
  output logic                 bpred_miss,
  output logic [BIMODAL_W-1:0] bpred_carry,
  output logic                 miss_pred,
  output logic [31:0]          redirect_pc,
  output logic                 c_r_after_r,
  output logic                 is_call,
  output logic                 squash_active,
  output logic [31:0]          dbg_count
);

  import bpred_pkg::*;

  squash_state_t state;
  logic [3:0]    squash_cnt;
  logic          last_was_return;
  logic [31:0]   resolved_count;
  logic [31:0]   miss_count;
  logic          cap;
  logic          miss;

  assign cap  = ex_valid && ex_is_branch && !stall && (state == IDLE);
  assign miss = branch_miss(ex_pred_dir, ex_taken, ex_pred_target, ex_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      squash_cnt      <= '0;
      last_was_return <= 1'b0;
      resolved_count  <= '0;
      miss_count      <= '0;
      bpred_update    <= 1'b0;
      bpred_pc4       <= '0;
      bpred_target    <= '0;
      bpred_dir       <= 1'b0;
      bpred_miss      <= 1'b0;
      bpred_carry     <= '0;
      miss_pred       <= 1'b0;
      redirect_pc     <= '0;
      c_r_after_r     <= 1'b0;
      is_call         <= 1'b0;
    end else begin
      bpred_update <= 1'b0;
      miss_pred    <= 1'b0;
      case (state)
        IDLE: begin
          if (cap) begin
            bpred_update    <= 1'b1;
            bpred_pc4       <= ex_pc4;
            bpred_target    <= ex_target;
            bpred_dir       <= ex_taken;
            bpred_miss      <= miss;
            bpred_carry     <= ex_carry;
            is_call         <= ex_is_call;
            c_r_after_r     <= (ex_is_call || ex_is_return) && last_was_return;
            last_was_return <= ex_is_return;
            resolved_count  <= resolved_count + 32'd1;
            if (miss) begin
              miss_pred   <= 1'b1;
              redirect_pc <= ex_taken ? ex_target : ex_pc4;
              miss_count  <= miss_count + 32'd1;
              state       <= SQUASH;
              squash_cnt  <= 4'(SQUASH_CYCLES);
            end
          end
        end
        SQUASH: begin
          // Wrong-path instructions are dropped; only the countdown advances.
          if (!stall) begin
            if (squash_cnt <= 4'd1) begin
              squash_cnt <= '0;
              state      <= IDLE;
            end else begin
              squash_cnt <= squash_cnt - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign squash_active = (state == SQUASH);
  assign dbg_count     = dbg_sel ? miss_count : resolved_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int SQ = 2;
  localparam int BW = 12;

  logic          clk = 1'b0;
  logic          reset, stall, ex_valid, ex_is_branch, ex_is_call, ex_is_return, ex_taken;
  logic [31:0]   ex_target, ex_pc4, ex_pred_target;
  logic          ex_pred_dir, dbg_sel;
  logic [BW-1:0] ex_carry;
  logic          bpred_update, bpred_dir, bpred_miss, miss_pred, c_r_after_r, is_call, squash_active;
  logic [31:0]   bpred_pc4, bpred_target, redirect_pc, dbg_count;
  logic [BW-1:0] bpred_carry;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic          m_update, m_dir, m_miss, m_miss_pred, m_crr, m_call, m_last_ret;
  logic [31:0]   m_pc4, m_target, m_redirect, m_resolved, m_misses;
  logic [BW-1:0] m_carry;
  int            m_squash_left;

  branch_resolve_unit #(.SQUASH_CYCLES(SQ), .BIMODAL_W(BW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_call(ex_is_call), .ex_is_return(ex_is_return), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pc4(ex_pc4), .ex_pred_dir(ex_pred_dir), .ex_pred_target(ex_pred_target), .ex_carry(ex_carry),
    .dbg_sel(dbg_sel), .bpred_update(bpred_update), .bpred_pc4(bpred_pc4), .bpred_target(bpred_target),
    .bpred_dir(bpred_dir), .bpred_miss(bpred_miss), .bpred_carry(bpred_carry), .miss_pred(miss_pred),
    .redirect_pc(redirect_pc), .c_r_after_r(c_r_after_r), .is_call(is_call),
    .squash_active(squash_active), .dbg_count(dbg_count)
  );

  always #5 clk = ~clk;

  task automatic set_br(input logic v, input logic br, input logic call, input logic ret,
                        input logic taken, input logic [31:0] tgt, input logic [31:0] pc4,
                        input logic pdir, input logic [31:0] ptgt);
    ex_valid = v; ex_is_branch = br; ex_is_call = call; ex_is_return = ret;
    ex_taken = taken; ex_target = tgt; ex_pc4 = pc4; ex_pred_dir = pdir; ex_pred_target = ptgt;
    ex_carry = BW'($urandom);
  endtask

  // Advance the model from the specification rules, then clock the DUT.
  task automatic cycle();
    logic cap, mis;
    cap = !reset && ex_valid && ex_is_branch && !stall && (m_squash_left == 0);
    mis = (ex_pred_dir != ex_taken) || (ex_taken && (ex_pred_target != ex_target));
    if (reset) begin
      m_update = 0; m_dir = 0; m_miss = 0; m_miss_pred = 0; m_crr = 0; m_call = 0; m_last_ret = 0;
      m_pc4 = 0; m_target = 0; m_redirect = 0; m_resolved = 0; m_misses = 0; m_carry = 0;
      m_squash_left = 0;
    end else begin
      m_update = cap;
      m_miss_pred = 0;
      if (m_squash_left > 0 && !stall) m_squash_left--;
      if (cap) begin
        m_pc4 = ex_pc4; m_target = ex_target; m_dir = ex_taken; m_miss = mis; m_carry = ex_carry;
        m_call = ex_is_call;
        m_crr = (ex_is_call || ex_is_return) && m_last_ret;
        m_last_ret = ex_is_return;
        m_resolved++;
        if (mis) begin
          m_miss_pred = 1;
          m_redirect = ex_taken ? ex_target : ex_pc4;
          m_squash_left = SQ;
          m_misses++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_br(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      cycle();
    end
  endtask

  task automatic test_reset();
    reset = 1; stall = 0;
    set_br(1, 1, 1, 0, 1, 32'h1234, 32'h8, 0, 32'h0);
    cycle(); cycle();
    reset = 0;
    checks++;
    if ({bpred_update, bpred_miss, miss_pred, c_r_after_r, is_call, squash_active, bpred_dir} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0",
        {bpred_update, bpred_miss, miss_pred, c_r_after_r, is_call, squash_active, bpred_dir});
    end
    checks++;
    if ({bpred_pc4, bpred_target, redirect_pc, bpred_carry} !== '0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {bpred_pc4, bpred_target, redirect_pc, bpred_carry});
    end
    dbg_sel = 0; #1;
    checks++;
    if (dbg_count !== 32'd0) begin errors++; $display("FAIL reset_resolved got=%0d exp=0", dbg_count); end
    dbg_sel = 1; #1;
    checks++;
    if (dbg_count !== 32'd0) begin errors++; $display("FAIL reset_misses got=%0d exp=0", dbg_count); end
  endtask

  task automatic test_correct_branch();
    set_br(1, 1, 0, 0, 1, 32'h100, 32'h44, 1, 32'h100);
    cycle();
    checks++;
    if ({bpred_update, bpred_miss, miss_pred} !== 3'b100) begin
      errors++; $display("FAIL correct_strobes got=%b exp=100", {bpred_update, bpred_miss, miss_pred});
    end
    checks++;
    if (bpred_target !== 32'h100 || bpred_pc4 !== 32'h44) begin
      errors++; $display("FAIL correct_data got=%h/%h exp=100/44", bpred_target, bpred_pc4);
    end
    idle(1);
    checks++;
    if (bpred_update !== 1'b0 || bpred_target !== 32'h100) begin
      errors++; $display("FAIL update_pulse got=%b/%h exp=0/100", bpred_update, bpred_target);
    end
  endtask

  task automatic test_mispredict_squash();
    set_br(1, 1, 0, 0, 0, 32'h500, 32'h80, 1, 32'h500);
    cycle();
    checks++;
    if (miss_pred !== 1'b1 || redirect_pc !== 32'h80 || squash_active !== 1'b1) begin
      errors++; $display("FAIL mispredict got=%b/%h/%b exp=1/80/1", miss_pred, redirect_pc, squash_active);
    end
    set_br(1, 1, 0, 0, 1, 32'h600, 32'h90, 1, 32'h600);
    cycle();
    checks++;
    if (bpred_update !== 1'b0 || miss_pred !== 1'b0 || squash_active !== 1'b1) begin
      errors++; $display("FAIL squash_1 got=%b/%b/%b exp=0/0/1", bpred_update, miss_pred, squash_active);
    end
    set_br(1, 1, 0, 0, 1, 32'h700, 32'ha0, 1, 32'h700);
    cycle();
    checks++;
    if (bpred_update !== 1'b0 || squash_active !== 1'b0) begin
      errors++; $display("FAIL squash_2 got=%b/%b exp=0/0", bpred_update, squash_active);
    end
    set_br(1, 1, 0, 0, 1, 32'h800, 32'hb0, 1, 32'h800);
    cycle();
    checks++;
    if (bpred_update !== 1'b1 || bpred_target !== 32'h800) begin
      errors++; $display("FAIL after_squash got=%b/%h exp=1/800", bpred_update, bpred_target);
    end
  endtask

  task automatic test_wrong_target();
    set_br(1, 1, 0, 0, 1, 32'h300, 32'hc4, 1, 32'h200);
    cycle();
    checks++;
    if (bpred_miss !== 1'b1 || miss_pred !== 1'b1 || redirect_pc !== 32'h300) begin
      errors++; $display("FAIL wrong_target got=%b/%b/%h exp=1/1/300", bpred_miss, miss_pred, redirect_pc);
    end
    idle(SQ);
  endtask

  task automatic test_ras();
    set_br(1, 1, 0, 1, 1, 32'h1000, 32'h20, 1, 32'h1000);
    cycle();
    set_br(1, 1, 1, 0, 1, 32'h2000, 32'h24, 1, 32'h2000);
    cycle();
    checks++;
    if (c_r_after_r !== 1'b1 || is_call !== 1'b1) begin
      errors++; $display("FAIL ret_then_call got=%b/%b exp=1/1", c_r_after_r, is_call);
    end
    set_br(1, 1, 1, 0, 1, 32'h3000, 32'h2004, 1, 32'h3000);
    cycle();
    checks++;
    if (c_r_after_r !== 1'b0 || is_call !== 1'b1) begin
      errors++; $display("FAIL call_then_call got=%b/%b exp=0/1", c_r_after_r, is_call);
    end
  endtask

  task automatic test_stall_squash();
    set_br(1, 1, 0, 0, 1, 32'h40, 32'h10, 0, 32'h0);
    cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_br(1, 1, 0, 0, 0, 32'h0, 32'h14, 1, 32'h0);
      cycle();
      checks++;
      if (squash_active !== 1'b1 || bpred_update !== 1'b0 || miss_pred !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d got=%b/%b/%b exp=1/0/0", i, squash_active, bpred_update, miss_pred);
      end
    end
    stall = 0;
    idle(1);
    checks++;
    if (squash_active !== 1'b1) begin errors++; $display("FAIL stall_resume got=%b exp=1", squash_active); end
    idle(1);
    checks++;
    if (squash_active !== 1'b0) begin errors++; $display("FAIL stall_done got=%b exp=0", squash_active); end
    set_br(1, 1, 0, 0, 1, 32'h40, 32'h10, 0, 32'h0);
    cycle();
    reset = 1;
    set_br(1, 1, 1, 1, 1, 32'h44, 32'h18, 0, 32'h0);
    cycle();
    reset = 0;
    checks++;
    if ({bpred_update, miss_pred, squash_active, bpred_miss, is_call, redirect_pc, bpred_pc4} !== '0) begin
      errors++; $display("FAIL reset_mid_squash got=%h exp=0",
        {bpred_update, miss_pred, squash_active, bpred_miss, is_call, redirect_pc, bpred_pc4});
    end
  endtask

  task automatic test_counters();
    reset = 1; idle(1); reset = 0;
    set_br(1, 1, 0, 0, 1, 32'h10, 32'h4, 1, 32'h10); cycle();
    set_br(1, 1, 0, 0, 1, 32'h20, 32'h8, 0, 32'h20); cycle();
    idle(SQ);
    set_br(1, 1, 0, 0, 0, 32'h30, 32'hc, 0, 32'h30); cycle();
    set_br(1, 1, 0, 0, 1, 32'h40, 32'h10, 1, 32'h44); cycle();
    idle(SQ);
    set_br(1, 1, 0, 0, 1, 32'h50, 32'h14, 1, 32'h50); cycle();
    dbg_sel = 0; #1;
    checks++;
    if (dbg_count !== 32'd5) begin errors++; $display("FAIL resolved_count got=%0d exp=5", dbg_count); end
    dbg_sel = 1; #1;
    checks++;
    if (dbg_count !== 32'd2) begin errors++; $display("FAIL miss_count got=%0d exp=2", dbg_count); end
  endtask

  task automatic test_random();
    logic [146:0] got, exp;
    logic t, pd;
    logic [31:0] tg, pt;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 99) < 15);
      t  = 1'($urandom);
      pd = ($urandom_range(0, 3) == 0) ? ~t : t;
      tg = $urandom;
      pt = ($urandom_range(0, 4) == 0) ? $urandom : tg;
      set_br($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
             t, tg, $urandom, pd, pt);
      dbg_sel = 1'($urandom);
      cycle();
      got = {bpred_update, bpred_pc4, bpred_target, bpred_dir, bpred_miss, bpred_carry, miss_pred,
             redirect_pc, c_r_after_r, is_call, squash_active, dbg_count};
      exp = {m_update, m_pc4, m_target, m_dir, m_miss, m_carry, m_miss_pred,
             m_redirect, m_crr, m_call, (m_squash_left > 0), (dbg_sel ? m_misses : m_resolved)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_%0d got=%h exp=%h", i, got, exp);
      end
    end
    reset = 0; stall = 0;
  endtask

  initial begin
    reset = 1; stall = 0; dbg_sel = 0;
    set_br(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    test_reset();
    test_correct_branch();
    test_mispredict_squash();
    idle(SQ);
    test_wrong_target();
    test_ras();
    idle(SQ);
    test_stall_squash();
    test_counters();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
